// File: rtl/dmi_boot_sequencer.sv
// DMI master: streams a boot image into SRAM over system bus access,
// then halts Ibex, writes DPC through an abstract command and resumes.
module dmi_boot_sequencer #(
    parameter int unsigned POLL_MAX = 1024,
    parameter logic [31:0] SBCS_CFG = 32'h0005_0000,
    parameter int unsigned HALT_BIT = 9
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] sec_addr_i,
    input  logic [31:0] start_addr_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [31:0] word_data_i,
    input  logic        word_last_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_op_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  err_code_o
);

    localparam int unsigned CW = $clog2(POLL_MAX + 1);

    localparam logic [6:0] A_DMCTRL = 7'h10;
    localparam logic [6:0] A_DMSTAT = 7'h11;
    localparam logic [6:0] A_DATA0  = 7'h04;
    localparam logic [6:0] A_ACS    = 7'h16;
    localparam logic [6:0] A_CMD    = 7'h17;
    localparam logic [6:0] A_SBCS   = 7'h38;
    localparam logic [6:0] A_SBADDR = 7'h39;
    localparam logic [6:0] A_SBDATA = 7'h3C;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] RSP_FAIL = 2'd2;
    localparam logic [1:0] RSP_BUSY = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_CFG,
        S_ADDR,
        S_POLLSB,
        S_FETCH,
        S_DATA,
        S_HALT,
        S_WHALT,
        S_CMD,
        S_WCMD,
        S_RESUME,
        S_DONE,
        S_ERROR
    } state_e;

    state_e         state_q, state_d;
    logic           phase_q, phase_d;
    logic           step_q, step_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     err_q, err_d;
    logic [31:0]    sec_addr_q, sec_addr_d;
    logic [31:0]    start_addr_q, start_addr_d;
    logic [31:0]    word_q, word_d;
    logic           last_q, last_d;

    logic           txn;
    logic [6:0]     req_addr;
    logic [1:0]     req_op;
    logic [31:0]    req_data;
    logic           rsp_ok;
    logic [CW-1:0]  cnt_inc;
    logic           poll_last;
    logic           unused_resp;

    assign cnt_inc     = cnt_q + CW'(1);
    assign poll_last   = (cnt_inc == CW'(POLL_MAX));
    assign unused_resp = ^dmi_resp_data_i;

    // Request contents depend only on state and captured values,
    // so they stay stable for the whole request phase.
    always_comb begin
        txn      = 1'b0;
        req_addr = '0;
        req_op   = OP_NOP;
        req_data = '0;
        unique case (state_q)
            S_ACT: begin
                txn      = 1'b1;
                req_addr = A_DMCTRL;
                req_op   = OP_WR;
                req_data = 32'h0000_0001;
            end
            S_CFG: begin
                txn      = 1'b1;
                req_addr = A_SBCS;
                req_op   = OP_WR;
                req_data = SBCS_CFG;
            end
            S_ADDR: begin
                txn      = 1'b1;
                req_addr = A_SBADDR;
                req_op   = OP_WR;
                req_data = sec_addr_q;
            end
            S_POLLSB: begin
                txn      = 1'b1;
                req_addr = A_SBCS;
                req_op   = OP_RD;
            end
            S_DATA: begin
                txn      = 1'b1;
                req_addr = A_SBDATA;
                req_op   = OP_WR;
                req_data = word_q;
            end
            S_HALT: begin
                txn      = 1'b1;
                req_op   = OP_WR;
                req_addr = step_q ? A_DMCTRL : A_DATA0;
                req_data = step_q ? 32'h8000_0001 : start_addr_q;
            end
            S_WHALT: begin
                txn      = 1'b1;
                req_addr = A_DMSTAT;
                req_op   = OP_RD;
            end
            S_CMD: begin
                txn      = 1'b1;
                req_op   = OP_WR;
                req_addr = step_q ? A_CMD : A_DMCTRL;
                req_data = step_q ? 32'h0023_07B1 : 32'h0000_0001;
            end
            S_WCMD: begin
                txn      = 1'b1;
                req_addr = A_ACS;
                req_op   = OP_RD;
            end
            S_RESUME: begin
                txn      = 1'b1;
                req_addr = A_DMCTRL;
                req_op   = OP_WR;
                req_data = step_q ? 32'h0000_0001 : 32'h4000_0001;
            end
            default: ;
        endcase
    end

    assign dmi_req_valid_o  = txn && !phase_q;
    assign dmi_resp_ready_o = txn && phase_q;
    assign dmi_req_addr_o   = dmi_req_valid_o ? req_addr : '0;
    assign dmi_req_op_o     = dmi_req_valid_o ? req_op : OP_NOP;
    assign dmi_req_data_o   = dmi_req_valid_o ? req_data : '0;

    assign word_ready_o = (state_q == S_FETCH);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERROR);
    assign busy_o       = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign err_code_o   = err_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        sec_addr_d   = sec_addr_q;
        start_addr_d = start_addr_q;
        word_d       = word_q;
        last_d       = last_q;
        rsp_ok       = 1'b0;

        // A busy response leaves state untouched: the same request
        // is simply presented again.
        if (txn) begin
            if (!phase_q) begin
                if (dmi_req_ready_i) phase_d = 1'b1;
            end else if (dmi_resp_valid_i) begin
                phase_d = 1'b0;
                if (dmi_resp_op_i == RSP_FAIL) begin
                    state_d = S_ERROR;
                    step_d  = 1'b0;
                    err_d   = 3'd1;
                end else if (dmi_resp_op_i != RSP_BUSY) begin
                    rsp_ok = 1'b1;
                end
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d      = S_ACT;
                    phase_d      = 1'b0;
                    step_d       = 1'b0;
                    cnt_d        = '0;
                    err_d        = 3'd0;
                    last_d       = 1'b0;
                    sec_addr_d   = sec_addr_i;
                    start_addr_d = start_addr_i;
                end
            end
            S_ACT:  if (rsp_ok) state_d = S_CFG;
            S_CFG:  if (rsp_ok) state_d = S_ADDR;
            S_ADDR: if (rsp_ok) state_d = S_FETCH;
            S_POLLSB: begin
                if (rsp_ok) begin
                    if (dmi_resp_data_i[22] ||
                        (|dmi_resp_data_i[14:12])) begin
                        state_d = S_ERROR;
                        err_d   = 3'd3;
                    end else if (dmi_resp_data_i[21]) begin
                        if (poll_last) begin
                            state_d = S_ERROR;
                            err_d   = 3'd2;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (last_q) begin
                        state_d = S_HALT;
                        step_d  = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (word_valid_i) begin
                    word_d  = word_data_i;
                    last_d  = word_last_i;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rsp_ok) begin
                    state_d = S_POLLSB;
                    cnt_d   = '0;
                end
            end
            S_HALT: begin
                if (rsp_ok) begin
                    if (step_q) begin
                        state_d = S_WHALT;
                        step_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        step_d = 1'b1;
                    end
                end
            end
            S_WHALT: begin
                if (rsp_ok) begin
                    if (dmi_resp_data_i[HALT_BIT]) begin
                        state_d = S_CMD;
                        step_d  = 1'b0;
                    end else if (poll_last) begin
                        state_d = S_ERROR;
                        err_d   = 3'd2;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_CMD: begin
                if (rsp_ok) begin
                    if (step_q) begin
                        state_d = S_WCMD;
                        step_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        step_d = 1'b1;
                    end
                end
            end
            S_WCMD: begin
                if (rsp_ok) begin
                    if (dmi_resp_data_i[12]) begin
                        if (poll_last) begin
                            state_d = S_ERROR;
                            err_d   = 3'd2;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (|dmi_resp_data_i[10:8]) begin
                        state_d = S_ERROR;
                        err_d   = 3'd4;
                    end else begin
                        state_d = S_RESUME;
                        step_d  = 1'b0;
                    end
                end
            end
            S_RESUME: begin
                if (rsp_ok) begin
                    if (step_q) begin
                        state_d = S_DONE;
                        step_d  = 1'b0;
                    end else begin
                        step_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            step_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 3'd0;
            sec_addr_q   <= '0;
            start_addr_q <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            sec_addr_q   <= sec_addr_d;
            start_addr_q <= start_addr_d;
            word_q       <= word_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Bench for dmi_boot_sequencer: DM/SRAM model, image source and
// a scoreboard of expected DMI transactions.
module tb_dmi_boot_sequencer;

    localparam int PMAX = 16;
    localparam logic [31:0] SBCS = 32'h0005_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] sec_addr_i = '0;
    logic [31:0] start_addr_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic [31:0] word_data_i = '0;
    logic        word_last_i = 1'b0;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b0;
    logic [6:0]  dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i = '0;
    logic [1:0]  dmi_resp_op_i = '0;
    logic        busy_o, done_o, error_o;
    logic [2:0]  err_code_o;

    always #5 clk = ~clk;

    dmi_boot_sequencer #(.POLL_MAX(PMAX)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .sec_addr_i(sec_addr_i), .start_addr_i(start_addr_i),
        .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .word_data_i(word_data_i), .word_last_i(word_last_i),
        .dmi_req_valid_o(dmi_req_valid_o),
        .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
        .dmi_req_data_o(dmi_req_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i(dmi_resp_data_i),
        .dmi_resp_op_i(dmi_resp_op_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_code_o(err_code_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] sec;
        logic [31:0] pc;
        int          n;
        int          sb_after;
        int          sb_n;
        int          busy_w3c;
        bit          sberr;
        bit          halt_never;
        bit          poke;
        bit          exp_done;
        bit          exp_err;
        logic [2:0]  exp_code;
        int          exp_words;
    } tc_t;

    int tests = 0;
    int fails = 0;

    txn_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] words[$];
    logic [31:0] sbaddr;
    int wn, widx, sb_after, sb_n, sb_left, busy_left;
    int w3c_cnt, r38_cnt;
    bit sberr, halt_never;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {busy_o, done_o, error_o, err_code_o, dmi_req_valid_o,
                dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
                dmi_resp_ready_o, word_ready_o};
    endfunction

    task automatic push(input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] d);
        txn_t t;
        t.op = op;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic dm_respond(input txn_t t);
        logic [31:0] d = '0;
        logic [1:0]  o = 2'd0;
        if (t.op == 2'd2) begin
            if (t.addr == 7'h39) sbaddr = t.data;
            if (t.addr == 7'h3C) begin
                if (busy_left > 0) begin
                    o = 2'd3;
                    busy_left--;
                end else begin
                    mem[sbaddr] = t.data;
                    sbaddr += 4;
                    w3c_cnt++;
                    if (w3c_cnt == sb_after) sb_left = sb_n;
                end
            end
        end else if (t.op == 2'd1) begin
            if (t.addr == 7'h38) begin
                r38_cnt++;
                if (sberr) d = SBCS | 32'h0000_3000;
                else if (sb_left > 0) begin
                    d = SBCS | 32'h0020_0000;
                    sb_left--;
                end else d = SBCS;
            end
            if (t.addr == 7'h11)
                d = halt_never ? 32'h0000_0C02 : 32'h0000_0302;
            if (t.addr == 7'h16) d = 32'h0000_0001;
        end
        dmi_resp_data_i = d;
        dmi_resp_op_i = o;
    endtask

    initial begin : dm_model
        logic pv, pr, rv, rr, wv, wr;
        bit   pend;
        int   dly;
        txn_t pt, e;
        pv = 0; pr = 0; rv = 0; rr = 0; wv = 0; wr = 0;
        pend = 0; dly = 0;
        pt = '{2'd0, 7'd0, 32'd0};
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                dmi_req_ready_i = 0;
                dmi_resp_valid_i = 0;
                word_valid_i = 0;
                pv = 0; pr = 0; rv = 0; rr = 0; wv = 0; wr = 0;
                pend = 0;
                continue;
            end
            if (rv && rr) dmi_resp_valid_i = 0;
            if (wv && wr) widx++;
            if (pv && pr) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_txn: got op %0d addr %h, expected none",
                             pt.op, pt.addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_op_addr", {pt.op, pt.addr}, {e.op, e.addr});
                    if (e.op == 2'd2) chk("txn_data", pt.data, e.data);
                end
                dm_respond(pt);
                pend = 1;
                dly = $urandom_range(0, 2);
            end
            if (pend && !dmi_resp_valid_i) begin
                if (dly == 0) begin
                    dmi_resp_valid_i = 1;
                    pend = 0;
                end else dly--;
            end
            if (!dmi_req_valid_o) chk("op_nop_idle", dmi_req_op_o, 0);
            if (pv && !pr)
                chk("req_hold",
                    {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o,
                     dmi_req_data_o},
                    {1'b1, pt.addr, pt.op, pt.data});
            if (word_ready_o)
                chk("fetch_excl", dmi_req_valid_o | dmi_resp_ready_o, 0);
            dmi_req_ready_i = dmi_req_valid_o && !pend &&
                              !dmi_resp_valid_i &&
                              ($urandom_range(0, 3) != 0);
            word_valid_i = (widx < wn) && ($urandom_range(0, 3) != 0);
            word_data_i = (widx < wn) ? words[widx] : 32'd0;
            word_last_i = (widx == wn - 1);
            pv = dmi_req_valid_o;
            pr = dmi_req_ready_i;
            pt.op = dmi_req_op_o;
            pt.addr = dmi_req_addr_o;
            pt.data = dmi_req_data_o;
            rv = dmi_resp_valid_i;
            rr = dmi_resp_ready_o;
            wv = word_valid_i;
            wr = word_ready_o;
        end
    end

    task automatic setup(input tc_t tc);
        exp_q.delete();
        mem.delete();
        words.delete();
        for (int i = 0; i < tc.n; i++) words.push_back($urandom);
        wn = tc.n;
        widx = 0;
        sb_after = tc.sb_after;
        sb_n = tc.sb_n;
        sb_left = 0;
        busy_left = tc.busy_w3c;
        sberr = tc.sberr;
        halt_never = tc.halt_never;
        w3c_cnt = 0;
        r38_cnt = 0;
        push(2, 7'h10, 32'h1);
        push(2, 7'h38, SBCS);
        push(2, 7'h39, tc.sec);
        for (int i = 0; i < tc.n; i++) begin
            for (int k = 0; k <= ((i == 0) ? tc.busy_w3c : 0); k++)
                push(2, 7'h3C, words[i]);
            push(1, 7'h38, 0);
            if (tc.sberr) return;
            if (i + 1 == tc.sb_after)
                for (int k = 0; k < tc.sb_n; k++) push(1, 7'h38, 0);
        end
        push(2, 7'h04, tc.pc);
        push(2, 7'h10, 32'h8000_0001);
        if (tc.halt_never) begin
            for (int k = 0; k < PMAX; k++) push(1, 7'h11, 0);
            return;
        end
        push(1, 7'h11, 0);
        push(2, 7'h10, 32'h1);
        push(2, 7'h17, 32'h0023_07B1);
        push(1, 7'h16, 0);
        push(2, 7'h10, 32'h4000_0001);
        push(2, 7'h10, 32'h1);
    endtask

    task automatic pulse_start(input tc_t tc);
        start_i = 1;
        sec_addr_i = tc.sec;
        start_addr_i = tc.pc;
        @(negedge clk);
        #1;
        start_i = 0;
        sec_addr_i = $urandom;
        start_addr_i = $urandom;
    endtask

    task automatic run_case(input tc_t tc, input int id);
        string nm;
        int cyc;
        logic [31:0] a;
        nm = $sformatf("c%0d", id);
        setup(tc);
        pulse_start(tc);
        chk({nm, "_busy"}, {busy_o, done_o, error_o}, 3'b100);
        cyc = 0;
        while (!(done_o || error_o) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_i = tc.poke && (cyc == 20);
        end
        start_i = 0;
        chk({nm, "_timeout"}, cyc < 4000, 1);
        repeat (20) @(negedge clk);
        #1;
        chk({nm, "_done"}, done_o, tc.exp_done);
        chk({nm, "_error"}, error_o, tc.exp_err);
        chk({nm, "_code"}, err_code_o, tc.exp_code);
        chk({nm, "_idle_busy"}, busy_o, 0);
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_words"}, widx, tc.exp_words);
        chk({nm, "_r38"}, r38_cnt, tc.sberr ? 1 : tc.n + tc.sb_n);
        chk({nm, "_sram_n"}, mem.size(), tc.exp_words);
        for (int i = 0; i < tc.exp_words; i++) begin
            a = tc.sec + 32'(4 * i);
            chk({nm, "_sram"}, mem.exists(a) ? mem[a] : 32'hDEAD_BEEF,
                words[i]);
        end
    endtask

    tc_t tbl[7];
    int  cyc;

    initial begin
        tbl[0] = '{32'h1C00_0000, 32'h1C00_0080, 3, 0, 0, 0,
                   0, 0, 0, 1, 0, 3'd0, 3};
        tbl[1] = '{32'h1C00_1000, 32'h1C00_1000, 3, 2, 5, 0,
                   0, 0, 0, 1, 0, 3'd0, 3};
        tbl[2] = '{32'h1C00_2000, 32'h1C00_2004, 3, 0, 0, 1,
                   0, 0, 0, 1, 0, 3'd0, 3};
        tbl[3] = '{32'h1C00_3000, 32'h1C00_3000, 3, 0, 0, 0,
                   1, 0, 0, 0, 1, 3'd3, 1};
        tbl[4] = '{32'h2000_0000, 32'h2000_0040, 5, 0, 0, 0,
                   0, 0, 1, 1, 0, 3'd0, 5};
        tbl[5] = '{32'h1C00_4000, 32'h1C00_4000, 2, 0, 0, 0,
                   0, 1, 0, 0, 1, 3'd2, 2};
        tbl[6] = '{32'h3000_0100, 32'h3000_0000, 1, 0, 0, 0,
                   0, 0, 0, 1, 0, 3'd0, 1};
        #1;
        chk("reset_outs", outs(), 0);
        repeat (3) @(negedge clk);
        #1;
        rst_ni = 1;
        @(negedge clk);
        #1;
        chk("idle_outs", outs(), 0);
        for (int i = 0; i < 7; i++) run_case(tbl[i], i);

        setup(tbl[0]);
        pulse_start(tbl[0]);
        cyc = 0;
        while (!(dmi_req_valid_o && dmi_req_addr_o == 7'h3C) &&
               cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_data", cyc < 2000, 1);
        #2;
        rst_ni = 0;
        #1;
        chk("async_rst_outs", outs(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        rst_ni = 1;
        run_case(tbl[0], 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
